multicycle_controller: RTL and testbench

- Control unit that sequences the team's ARM-subset datapath in multicycle form: one shared memory port, one ALU reused for PC increment, address generation and execution.
- Decodes the latched instruction and holds the NZCV condition flags.
- Walks a per-instruction state machine and drives every datapath select and enable line.
- Sits beside the datapath in the processor top level; all datapath strobes come from this block.

---
 rtl/multicycle_controller_if.sv | 28 ++
 rtl/multicycle_controller.sv | 176 +++++++++++++++++
 tb/tb_multicycle_controller.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: instruction/flag inputs and datapath control strobes between controller and datapath.
interface multicycle_controller_if;
    logic [31:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite;
    logic        AdrSrc;
    logic        MemWrite;
    logic        IRWrite;
    logic [1:0]  ResultSrc;
    logic        ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [1:0]  ALUControl;
    logic [1:0]  ImmSrc;
    logic [1:0]  RegSrc;
    logic        RegWrite;

    modport master (
        input  Instr, ALUFlags,
        output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ALUControl, ImmSrc, RegSrc, RegWrite
    );

    modport slave (
        output Instr, ALUFlags,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ALUControl, ImmSrc, RegSrc, RegWrite
    );
endinterface

// File: rtl/multicycle_controller.sv
// multicycle_controller: sequences the shared-memory, shared-ALU datapath per instruction and holds NZCV flags.
module multicycle_controller (
    input  logic                    clk,
    input  logic                    reset,
    multicycle_controller_if.master bus
);
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] flags_q, flags_d;
    logic       condex_q, condex_d;

    logic [3:0] cond, cmd, rd;
    logic [1:0] op;
    logic [5:0] funct;
    logic       n, z, c, v;
    logic       condex;
    logic [1:0] alu_dec;
    logic       no_write, arith;
    logic       next_pc, branch, reg_w, mem_w, ir_write, alu_op, pcs;
    logic       unused_bits;

    assign cond  = bus.Instr[31:28];
    assign op    = bus.Instr[27:26];
    assign funct = bus.Instr[25:20];
    assign rd    = bus.Instr[15:12];
    assign cmd   = funct[4:1];
    assign {n, z, c, v} = flags_q;
    assign unused_bits = &{1'b0, bus.Instr[19:16], bus.Instr[11:0]};

    always_comb begin
        case (cond)
            4'b0000: condex = z;
            4'b0001: condex = ~z;
            4'b0010: condex = c;
            4'b0011: condex = ~c;
            4'b0100: condex = n;
            4'b0101: condex = ~n;
            4'b0110: condex = v;
            4'b0111: condex = ~v;
            4'b1000: condex = c & ~z;
            4'b1001: condex = ~c | z;
            4'b1010: condex = n == v;
            4'b1011: condex = n != v;
            4'b1100: condex = ~z & (n == v);
            4'b1101: condex = z | (n != v);
            4'b1110: condex = 1'b1;
            default: condex = 1'b0;
        endcase
    end

    // Unrecognised commands fall back to ADD but never write a register.
    always_comb begin
        alu_dec  = 2'b00;
        no_write = 1'b0;
        case (cmd)
            4'b0100: alu_dec = 2'b00;
            4'b0010: alu_dec = 2'b01;
            4'b0000: alu_dec = 2'b10;
            4'b1100: alu_dec = 2'b11;
            4'b1010: begin
                alu_dec  = 2'b01;
                no_write = 1'b1;
            end
            default: no_write = 1'b1;
        endcase
    end

    assign arith = (cmd == 4'b0100) | (cmd == 4'b0010) | (cmd == 4'b1010);

    always_comb begin
        state_d           = state_q;
        next_pc           = 1'b0;
        branch            = 1'b0;
        reg_w             = 1'b0;
        mem_w             = 1'b0;
        ir_write          = 1'b0;
        alu_op            = 1'b0;
        bus.AdrSrc        = 1'b0;
        bus.ResultSrc     = 2'b00;
        bus.ALUSrcA       = 1'b0;
        bus.ALUSrcB       = 2'b00;
        case (state_q)
            FETCH: begin
                ir_write      = 1'b1;
                next_pc       = 1'b1;
                bus.ALUSrcA   = 1'b1;
                bus.ALUSrcB   = 2'b10;
                bus.ResultSrc = 2'b10;
                state_d       = DECODE;
            end
            DECODE: begin
                bus.ALUSrcA   = 1'b1;
                bus.ALUSrcB   = 2'b10;
                bus.ResultSrc = 2'b10;
                case (op)
                    2'b01:   state_d = MEMADR;
                    2'b00:   state_d = funct[5] ? EXECUTEI : EXECUTER;
                    2'b10:   state_d = BRANCH;
                    default: state_d = FETCH;
                endcase
            end
            MEMADR: begin
                bus.ALUSrcB = 2'b01;
                state_d     = funct[0] ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                bus.AdrSrc = 1'b1;
                state_d    = MEMWB;
            end
            MEMWB: begin
                bus.ResultSrc = 2'b01;
                reg_w         = 1'b1;
                state_d       = FETCH;
            end
            MEMWRITE: begin
                bus.AdrSrc = 1'b1;
                mem_w      = 1'b1;
                state_d    = FETCH;
            end
            EXECUTER: begin
                alu_op  = 1'b1;
                state_d = ALUWB;
            end
            EXECUTEI: begin
                bus.ALUSrcB = 2'b01;
                alu_op      = 1'b1;
                state_d     = ALUWB;
            end
            ALUWB: begin
                reg_w   = ~no_write;
                state_d = FETCH;
            end
            BRANCH: begin
                bus.ALUSrcB   = 2'b01;
                bus.ResultSrc = 2'b10;
                branch        = 1'b1;
                state_d       = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

    // The condition is frozen at DECODE so this instruction's own flag update cannot gate its writes.
    always_comb begin
        flags_d  = flags_q;
        condex_d = (state_q == DECODE) ? condex : condex_q;
        if ((state_q == EXECUTER || state_q == EXECUTEI) && funct[0] && condex_q) begin
            flags_d[3:2] = bus.ALUFlags[3:2];
            if (arith) flags_d[1:0] = bus.ALUFlags[1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= FETCH;
            flags_q  <= 4'b0000;
            condex_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            flags_q  <= flags_d;
            condex_q <= condex_d;
        end
    end

    assign pcs            = branch | (reg_w & (rd == 4'hF));
    assign bus.PCWrite    = reset & (next_pc | (pcs & condex_q));
    assign bus.RegWrite   = reset & reg_w & condex_q & (rd != 4'hF);
    assign bus.MemWrite   = reset & mem_w & condex_q;
    assign bus.IRWrite    = reset & ir_write;
    assign bus.ALUControl = alu_op ? alu_dec : 2'b00;
    assign bus.ImmSrc     = op;
    assign bus.RegSrc     = {op == 2'b01, op == 2'b10};
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: scoreboard bench; driver queues per-cycle expected control vectors from an instruction-level model.
module tb_multicycle_controller;
    logic clk = 1'b0;
    logic reset;
    multicycle_controller_if bus();
    multicycle_controller dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    logic [15:0] exp_q[$];
    string       name_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [3:0]  flags_m;

    function automatic logic [15:0] pack(logic pcw, logic adr, logic memw, logic irw, logic [1:0] rs,
                                         logic sa, logic [1:0] sb, logic [1:0] alu, logic [31:0] ins, logic rw);
        return {pcw, adr, memw, irw, rs, sa, sb, alu, ins[27:26], ins[27:26] == 2'b01, ins[27:26] == 2'b10, rw};
    endfunction

    function automatic bit cond_ok(logic [3:0] cc, logic [3:0] f);
        bit fn = f[3], fz = f[2], fc = f[1], fv = f[0];
        case (cc)
            4'd0:  return fz;
            4'd1:  return !fz;
            4'd2:  return fc;
            4'd3:  return !fc;
            4'd4:  return fn;
            4'd5:  return !fn;
            4'd6:  return fv;
            4'd7:  return !fv;
            4'd8:  return fc && !fz;
            4'd9:  return !fc || fz;
            4'd10: return fn == fv;
            4'd11: return fn != fv;
            4'd12: return !fz && fn == fv;
            4'd13: return fz || fn != fv;
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] alu_of(logic [3:0] cmd);
        if (cmd == 4'b0010 || cmd == 4'b1010) return 2'b01;
        if (cmd == 4'b0000) return 2'b10;
        if (cmd == 4'b1100) return 2'b11;
        return 2'b00;
    endfunction

    function automatic bit writes(logic [3:0] cmd);
        return cmd inside {4'b0100, 4'b0010, 4'b0000, 4'b1100};
    endfunction

    function automatic logic [15:0] exp_vec(string ph, logic [31:0] ins, bit ce);
        logic       pcw = 0, adr = 0, memw = 0, irw = 0, sa = 0, rw = 0;
        logic [1:0] rs = 0, sb = 0, alu = 0;
        bit         r15 = ins[15:12] == 4'hF;
        case (ph)
            "FETCH":    begin pcw = 1; irw = 1; sa = 1; sb = 2; rs = 2; end
            "DECODE":   begin sa = 1; sb = 2; rs = 2; end
            "MEMADR":   sb = 1;
            "MEMREAD":  adr = 1;
            "MEMWB":    begin rs = 1; rw = ce && !r15; pcw = ce && r15; end
            "MEMWRITE": begin adr = 1; memw = ce; end
            "EXECUTER": alu = alu_of(ins[24:21]);
            "EXECUTEI": begin sb = 1; alu = alu_of(ins[24:21]); end
            "ALUWB":    begin rw = writes(ins[24:21]) && ce && !r15; pcw = writes(ins[24:21]) && ce && r15; end
            "BRANCH":   begin sb = 1; rs = 2; pcw = ce; end
            default:    ;
        endcase
        return pack(pcw, adr, memw, irw, rs, sa, sb, alu, ins, rw);
    endfunction

    function automatic logic [15:0] rst_vec(logic [31:0] ins);
        return pack(0, 0, 0, 0, 2'b10, 1, 2'b10, 2'b00, ins, 0);
    endfunction

    task automatic push(string nm, logic [15:0] v);
        name_q.push_back(nm);
        exp_q.push_back(v);
    endtask

    // Walks one instruction; rst_phase >= 0 pulls reset low in that cycle for two cycles.
    task automatic run_instr(input logic [31:0] ins, input int rst_phase, input int fl);
        string ph[$];
        bit    ce;
        ph = '{"FETCH", "DECODE"};
        case (ins[27:26])
            2'b01: begin
                ph.push_back("MEMADR");
                if (ins[20]) begin ph.push_back("MEMREAD"); ph.push_back("MEMWB"); end
                else ph.push_back("MEMWRITE");
            end
            2'b00: begin ph.push_back(ins[25] ? "EXECUTEI" : "EXECUTER"); ph.push_back("ALUWB"); end
            2'b10: ph.push_back("BRANCH");
            default: ;
        endcase
        ce = cond_ok(ins[31:28], flags_m);
        for (int i = 0; i < ph.size(); i++) begin
            bus.Instr    = ins;
            bus.ALUFlags = (fl >= 0) ? fl[3:0] : 4'($urandom);
            if (i == rst_phase) begin
                reset   = 1'b0;
                flags_m = 4'b0000;
                push("reset_mid", rst_vec(ins));
                @(posedge clk); #1;
                push("reset_hold", rst_vec(ins));
                @(posedge clk); #1;
                reset = 1'b1;
                return;
            end
            push(ph[i], exp_vec(ph[i], ins, ce));
            if ((ph[i] == "EXECUTER" || ph[i] == "EXECUTEI") && ins[20] && ce) begin
                flags_m[3:2] = bus.ALUFlags[3:2];
                if (ins[24:21] inside {4'b0100, 4'b0010, 4'b1010}) flags_m[1:0] = bus.ALUFlags[1:0];
            end
            @(posedge clk); #1;
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [3:0]  cmd;
        r = $urandom;
        if (r[27:26] == 2'b00) begin
            case ($urandom_range(0, 7))
                0: cmd = 4'b0100;
                1: cmd = 4'b0010;
                2: cmd = 4'b0000;
                3: cmd = 4'b1100;
                4: cmd = 4'b1010;
                5: cmd = 4'b0001;
                6: cmd = 4'b0101;
                default: cmd = 4'b1111;
            endcase
            r[24:20] = {cmd, r[20] && (writes(cmd) || cmd == 4'b1010)};
        end
        if (r[2:0] == 3'b000) r[15:12] = 4'hF;
        return r;
    endfunction

    always @(negedge clk) begin
        logic [15:0] e, a;
        string       nm;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            a  = {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.ResultSrc, bus.ALUSrcA,
                  bus.ALUSrcB, bus.ALUControl, bus.ImmSrc, bus.RegSrc, bus.RegWrite};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL %s at %0t: controls=%h expected=%h", nm, $time, a, e);
            end
        end
    end

    initial begin
        reset        = 1'b0;
        bus.Instr    = 32'h0;
        bus.ALUFlags = 4'h0;
        flags_m      = 4'h0;
        @(posedge clk); #1;
        repeat (3) begin
            push("reset", rst_vec(32'h0));
            @(posedge clk); #1;
        end
        reset = 1'b1;
        run_instr(32'h05821000, -1, -1);
        run_instr(32'hE2821005, -1, -1);
        run_instr(32'hE3500000, -1, 4'b0100);
        run_instr(32'h12821005, -1, -1);
        run_instr(32'hE5921000, -1, -1);
        run_instr(32'hEA000002, -1, -1);
        run_instr(32'hE5921000, 4, -1);
        run_instr(32'h02821005, -1, -1);
        repeat (300) run_instr(rand_instr(), ($urandom_range(0, 39) == 0) ? int'($urandom_range(0, 4)) : -1, -1);
        repeat (2) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: pending=%0d expected=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
